// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - die codes, register map, bit indices and FSM states for dice_roll_ctrl
package dice_pkg;

  typedef enum logic [2:0] {
    DIE_D4      = 3'd0,
    DIE_D6      = 3'd1,
    DIE_D8      = 3'd2,
    DIE_D10     = 3'd3,
    DIE_D12     = 3'd4,
    DIE_D20     = 3'd5,
    DIE_D100    = 3'd6,
    DIE_INVALID = 3'd7
  } die_e;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h01;
  localparam logic [7:0] ADDR_RESULT = 8'h02;
  localparam logic [7:0] ADDR_DISP   = 8'h03;
  localparam logic [7:0] ADDR_COUNT  = 8'h04;
  localparam logic [7:0] ADDR_HIST   = 8'h05;

  localparam int CTRL_HOST_MODE = 0;
  localparam int CTRL_ROLL      = 1;
  localparam int CTRL_DIE_LSB   = 4;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ERR      = 2;
  localparam int STAT_SRC      = 3;
  localparam int STAT_HIST_LSB = 4;

  localparam int HIST_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    LATCH = 2'd3
  } state_e;

  // History level as reported in STATUS: a full FIFO still reads as 3
  function automatic logic [1:0] hist_level(input logic [2:0] n);
    return (n >= 3'd3) ? 2'd3 : n[1:0];
  endfunction

endpackage

// File: rtl/dice_hist_fifo.sv
// rtl/dice_hist_fifo.sv - 4x8 result history FIFO that overwrites its oldest entry when full
module dice_hist_fifo
  import dice_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic [2:0] level
);

  logic [7:0] mem [HIST_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] cnt;
  logic       pop_ok;
  logic       full;

  assign pop_ok = pop && (cnt != 3'd0);
  assign full   = (cnt == 3'(HIST_DEPTH));
  assign head   = (cnt != 3'd0) ? mem[rd_ptr] : 8'h00;
  assign level  = cnt;

  // Storage write; entries need no reset because cnt gates the head
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; a push into a full FIFO drops the oldest entry
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      cnt    <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop_ok || (push && full)) rd_ptr <= rd_ptr + 2'd1;
      if (push && !pop_ok && !full) cnt <= cnt + 3'd1;
      else if (pop_ok && !push)     cnt <= cnt - 3'd1;
    end
  end

endmodule

// File: rtl/dice_roll_ctrl.sv
// rtl/dice_roll_ctrl.sv - roll sequencer and register block; DICE_ROLL_HIST_EN adds the HIST FIFO
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter bit RESET_MODE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic       wen,
  input  logic [7:0] wdata,
  input  logic       rdata_used,
  output logic [7:0] rdata,
  input  logic       loc_req,
  input  logic [2:0] loc_die,
  output logic       dp_start,
  output logic [2:0] dp_die,
  input  logic       dp_done,
  input  logic [7:0] dp_result,
  output logic [7:0] disp_digits,
  output logic       disp_src
);

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

  state_e     state, state_n;
  logic       issue_loc, issue_host, wd_expire;
  logic       loc_pend, host_pend;
  logic [2:0] loc_die_q, host_die_q;
  logic       host_mode;
  logic [2:0] ctrl_die;
  logic       done_f, err_f, src_f;
  logic [7:0] result_q, disp_q, count_q, res_tmp, wd_cnt, rd_mux;
  logic [1:0] hist_lvl;
  logic       wr_ctrl, host_roll, host_bad, loc_bad, err_set, stat_clr, busy, latch;
  logic [2:0] host_die_in;

  assign wr_ctrl     = wen && (addr == ADDR_CTRL);
  assign host_die_in = wdata[CTRL_DIE_LSB +: 3];
  assign host_roll   = wr_ctrl && wdata[CTRL_ROLL];
  assign host_bad    = host_roll && (host_die_in == DIE_INVALID);
  assign loc_bad     = loc_req && (loc_die == DIE_INVALID);
  assign err_set     = wd_expire || loc_bad || host_bad;
  assign stat_clr    = rdata_used && rw && (addr == ADDR_STATUS);
  assign latch       = (state == LATCH);
  assign busy        = (state != IDLE) || loc_pend || host_pend;
  assign disp_src    = host_mode;
  assign disp_digits = host_mode ? disp_q : result_q;

  // Next state and start pulse; the local slot takes priority when both are pending
  always_comb begin
    state_n    = state;
    dp_start   = 1'b0;
    issue_loc  = 1'b0;
    issue_host = 1'b0;
    wd_expire  = 1'b0;
    case (state)
      IDLE: begin
        if (loc_pend) begin
          issue_loc = 1'b1;
          state_n   = ISSUE;
        end else if (host_pend) begin
          issue_host = 1'b1;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        dp_start = 1'b1;
        state_n  = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          state_n = LATCH;
        end else if (wd_cnt == WD_LAST) begin
          wd_expire = 1'b1;
          state_n   = IDLE;
        end
      end
      LATCH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and watchdog, which restarts from zero on every entry to WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wd_cnt <= 8'd0;
    end else begin
      state  <= state_n;
      wd_cnt <= (state == WAIT) ? wd_cnt + 8'd1 : 8'd0;
    end
  end

  // Request slots, issued die/source and the result captured with dp_done
  always_ff @(posedge clk) begin
    if (rst) begin
      loc_pend   <= 1'b0;
      host_pend  <= 1'b0;
      loc_die_q  <= 3'd0;
      host_die_q <= 3'd0;
      dp_die     <= 3'd0;
      src_f      <= 1'b0;
      res_tmp    <= 8'h00;
    end else begin
      if (issue_loc)  loc_pend  <= 1'b0;
      if (issue_host) host_pend <= 1'b0;
      // A slot being handed to the datapath this cycle counts as free
      if (loc_req && !loc_bad && (!loc_pend || issue_loc)) begin
        loc_pend  <= 1'b1;
        loc_die_q <= loc_die;
      end
      if (host_roll && !host_bad && (!host_pend || issue_host)) begin
        host_pend  <= 1'b1;
        host_die_q <= host_die_in;
      end
      if (issue_loc) begin
        dp_die <= loc_die_q;
        src_f  <= 1'b0;
      end else if (issue_host) begin
        dp_die <= host_die_q;
        src_f  <= 1'b1;
      end
      if ((state == WAIT) && dp_done) res_tmp <= dp_result;
    end
  end

  // Host-visible registers; sticky flags favour a set over a same-cycle read-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      host_mode <= RESET_MODE;
      ctrl_die  <= 3'd0;
      done_f    <= 1'b0;
      err_f     <= 1'b0;
      result_q  <= 8'h01;
      disp_q    <= 8'h00;
      count_q   <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        host_mode <= wdata[CTRL_HOST_MODE];
        ctrl_die  <= host_die_in;
      end
      if (latch && !src_f) host_mode <= 1'b0;
      if (wen && (addr == ADDR_DISP)) disp_q <= wdata;
      if (latch) begin
        result_q <= res_tmp;
        count_q  <= count_q + 8'd1;
      end
      if (latch)         done_f <= 1'b1;
      else if (stat_clr) done_f <= 1'b0;
      if (err_set)       err_f  <= 1'b1;
      else if (stat_clr) err_f  <= 1'b0;
    end
  end

`ifdef DICE_ROLL_HIST_EN
  logic [7:0] hist_head;
  logic [2:0] hist_cnt;

  dice_hist_fifo u_hist (
    .clk       (clk),
    .rst       (rst),
    .push      (latch),
    .push_data (res_tmp),
    .pop       (rdata_used && rw && (addr == ADDR_HIST)),
    .head      (hist_head),
    .level     (hist_cnt)
  );

  assign hist_lvl = hist_level(hist_cnt);
`else
  assign hist_lvl = 2'd0;
`endif

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_CTRL:   rd_mux = {1'b0, ctrl_die, 3'b000, host_mode};
      ADDR_STATUS: rd_mux = {2'b00, hist_lvl, src_f, err_f, done_f, busy};
      ADDR_RESULT: rd_mux = result_q;
      ADDR_DISP:   rd_mux = disp_q;
      ADDR_COUNT:  rd_mux = count_q;
`ifdef DICE_ROLL_HIST_EN
      ADDR_HIST:   rd_mux = hist_head;
`endif
      default:     rd_mux = 8'h00;
    endcase
  end

  // Registered read data
  always_ff @(posedge clk) begin
    if (rst) rdata <= 8'h00;
    else     rdata <= rd_mux;
  end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// tb/tb_dice_roll_ctrl.sv - self-checking bench for dice_roll_ctrl with a register-level reference model
module tb_dice_roll_ctrl;
  import dice_pkg::*;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst, rw, wen, rdata_used, loc_req, dp_done;
  logic [7:0] addr, wdata, rdata, dp_result, disp_digits;
  logic [2:0] loc_die, dp_die;
  logic       dp_start, disp_src;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_result, m_count, m_disp;
  logic       m_hm, m_done, m_err, m_src;
  logic [2:0] m_cdie;
  logic [7:0] hist_q[$];

  always #5 clk = ~clk;

  dice_roll_ctrl #(.TIMEOUT_CYC(TO), .RESET_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .rw(rw), .addr(addr), .wen(wen), .wdata(wdata),
    .rdata_used(rdata_used), .rdata(rdata), .loc_req(loc_req), .loc_die(loc_die),
    .dp_start(dp_start), .dp_die(dp_die), .dp_done(dp_done), .dp_result(dp_result),
    .disp_digits(disp_digits), .disp_src(disp_src)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rw = 1'b0; addr = 8'h00; wen = 1'b0; wdata = 8'h00; rdata_used = 1'b0;
    loc_req = 1'b0; loc_die = 3'd0; dp_done = 1'b0; dp_result = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    m_result = 8'h01; m_count = 8'h00; m_disp = 8'h00; m_hm = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_src = 1'b0; m_cdie = 3'd0; hist_q.delete();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; rw = 1'b0; wen = 1'b1; tick(); wen = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    addr = a; rw = 1'b1; tick(); tick(); d = rdata;
  endtask

  task automatic read_pop(input logic [7:0] a, output logic [7:0] d);
    addr = a; rw = 1'b1; tick(); tick(); d = rdata;
    rdata_used = 1'b1; tick(); rdata_used = 1'b0;
  endtask

  task automatic wait_start(output logic got, output logic [2:0] die);
    got = 1'b0; die = 3'd0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (dp_start) begin got = 1'b1; die = dp_die; end
      else tick();
    end
  endtask

  task automatic finish_roll(input logic [7:0] res, input int delay);
    repeat (delay) tick();
    dp_result = res; dp_done = 1'b1; tick(); dp_done = 1'b0; tick();
  endtask

  task automatic model_complete(input logic [7:0] res);
    m_result = res; m_count = m_count + 8'd1; m_done = 1'b1;
    if (!m_src) m_hm = 1'b0;
    if (hist_q.size() == HIST_DEPTH) void'(hist_q.pop_front());
    hist_q.push_back(res);
  endtask

  function automatic logic [7:0] exp_status();
    logic [1:0] lvl;
    lvl = 2'd0;
`ifdef DICE_ROLL_HIST_EN
    lvl = (hist_q.size() >= 3) ? 2'd3 : 2'(hist_q.size());
`endif
    return {2'b00, lvl, m_src, m_err, m_done, 1'b0};
  endfunction

  function automatic logic [7:0] exp_hist();
    logic [7:0] v;
    v = 8'h00;
`ifdef DICE_ROLL_HIST_EN
    if (hist_q.size() > 0) v = hist_q[0];
`endif
    return v;
  endfunction

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] a_list [7];
    logic [7:0] e_list [7];
    a_list = '{ADDR_CTRL, ADDR_STATUS, ADDR_RESULT, ADDR_DISP, ADDR_COUNT, ADDR_HIST, 8'h7F};
    e_list = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    idle_inputs(); rst = 1'b1; tick(); tick();
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
    checks++; if (dp_start !== 1'b0 || dp_die !== 3'd0) begin failures++; $display("FAIL rst_dp got=%b/%h exp=0/0", dp_start, dp_die); end
    checks++; if (disp_digits !== 8'h01 || disp_src !== 1'b0) begin failures++; $display("FAIL rst_disp got=%h/%b exp=01/0", disp_digits, disp_src); end
    rst = 1'b0; tick();
    for (int i = 0; i < 7; i++) begin
      peek(a_list[i], d);
      checks++; if (d !== e_list[i]) begin failures++; $display("FAIL rst_reg a=%h got=%h exp=%h", a_list[i], d, e_list[i]); end
    end
  endtask

  task automatic test_local_roll();
    logic [7:0] d;
    do_reset();
    loc_die = 3'd1; loc_req = 1'b1; tick(); loc_req = 1'b0;
    checks++; if (dp_start !== 1'b0) begin failures++; $display("FAIL loc_start_early got=%b exp=0", dp_start); end
    tick();
    checks++; if (dp_start !== 1'b1 || dp_die !== 3'd1) begin failures++; $display("FAIL loc_start got=%b/%h exp=1/1", dp_start, dp_die); end
    m_src = 1'b0;
    finish_roll(8'h05, 2); model_complete(8'h05);
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h05) begin failures++; $display("FAIL loc_result got=%h exp=05", d); end
    peek(ADDR_COUNT, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL loc_count got=%h exp=01", d); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin failures++; $display("FAIL loc_status got=%h exp=%h", d, exp_status()); end
  endtask

  task automatic test_arbitration();
    logic [7:0] d; logic got; logic [2:0] die;
    do_reset();
    loc_req = 1'b1; loc_die = 3'd0; addr = ADDR_CTRL; wdata = 8'h52; wen = 1'b1; tick();
    loc_req = 1'b0; wen = 1'b0; m_hm = 1'b0; m_cdie = 3'd5; tick();
    checks++; if (dp_start !== 1'b1 || dp_die !== 3'd0) begin failures++; $display("FAIL arb_first got=%b/%h exp=1/0", dp_start, dp_die); end
    m_src = 1'b0; finish_roll(8'h11, 3); model_complete(8'h11);
    wait_start(got, die);
    checks++; if (got !== 1'b1 || die !== 3'd5) begin failures++; $display("FAIL arb_second got=%b/%h exp=1/5", got, die); end
    m_src = 1'b1; finish_roll(8'h23, 1); model_complete(8'h23);
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin failures++; $display("FAIL arb_status got=%h exp=%h", d, exp_status()); end
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h23) begin failures++; $display("FAIL arb_result got=%h exp=23", d); end
    peek(ADDR_CTRL, d);
    checks++; if (d !== 8'h50) begin failures++; $display("FAIL arb_ctrl got=%h exp=50", d); end
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic got; logic [2:0] die;
    do_reset();
    loc_die = 3'd3; loc_req = 1'b1; tick(); loc_req = 1'b0;
    addr = ADDR_STATUS; rw = 1'b0;
    wait_start(got, die);
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", got); end
    repeat (TO + 1) tick();
    checks++; if (rdata[STAT_BUSY] !== 1'b1) begin failures++; $display("FAIL to_busy_last_wait got=%b exp=1", rdata[STAT_BUSY]); end
    tick();
    m_src = 1'b0; m_err = 1'b1;
    checks++; if (rdata !== exp_status()) begin failures++; $display("FAIL to_expired got=%h exp=%h", rdata, exp_status()); end
    dp_result = 8'h99; dp_done = 1'b1; tick(); dp_done = 1'b0;
    wait_start(got, die);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL to_restart got=%b exp=0", got); end
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL to_result got=%h exp=01", d); end
    peek(ADDR_COUNT, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL to_count got=%h exp=00", d); end
    read_pop(ADDR_STATUS, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL to_stat_read1 got=%h exp=04", d); end
    m_err = 1'b0;
    read_pop(ADDR_STATUS, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL to_stat_read2 got=%h exp=00", d); end
  endtask

  task automatic test_display();
    logic [7:0] d; logic got; logic [2:0] die;
    do_reset();
    write_reg(ADDR_DISP, 8'h42); write_reg(ADDR_CTRL, 8'h01); tick();
    checks++; if (disp_digits !== 8'h42 || disp_src !== 1'b1) begin failures++; $display("FAIL disp_host got=%h/%b exp=42/1", disp_digits, disp_src); end
    loc_die = 3'd4; loc_req = 1'b1; tick(); loc_req = 1'b0;
    wait_start(got, die);
    checks++; if (got !== 1'b1 || die !== 3'd4) begin failures++; $display("FAIL disp_start got=%b/%h exp=1/4", got, die); end
    finish_roll(8'h37, 2);
    checks++; if (disp_digits !== 8'h37 || disp_src !== 1'b0) begin failures++; $display("FAIL disp_forced got=%h/%b exp=37/0", disp_digits, disp_src); end
    write_reg(ADDR_CTRL, 8'h13);
    wait_start(got, die);
    checks++; if (got !== 1'b1 || die !== 3'd1) begin failures++; $display("FAIL disp_host_start got=%b/%h exp=1/1", got, die); end
    tick(); dp_result = 8'h58; dp_done = 1'b1; tick(); dp_done = 1'b0;
    addr = ADDR_DISP; wdata = 8'h66; rw = 1'b0; wen = 1'b1; tick(); wen = 1'b0;
    checks++; if (disp_digits !== 8'h66 || disp_src !== 1'b1) begin failures++; $display("FAIL disp_same_cycle got=%h/%b exp=66/1", disp_digits, disp_src); end
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h58) begin failures++; $display("FAIL disp_same_result got=%h exp=58", d); end
  endtask

  task automatic test_invalid();
    logic [7:0] d; logic got; logic [2:0] die;
    do_reset();
    loc_die = 3'd7; loc_req = 1'b1; tick(); loc_req = 1'b0;
    wait_start(got, die);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL inv_loc_start got=%b exp=0", got); end
    read_pop(ADDR_STATUS, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL inv_loc_status got=%h exp=04", d); end
    peek(ADDR_COUNT, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL inv_count got=%h exp=00", d); end
    write_reg(ADDR_CTRL, 8'h72);
    wait_start(got, die);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL inv_host_start got=%b exp=0", got); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL inv_host_status got=%h exp=04", d); end
    peek(ADDR_CTRL, d);
    checks++; if (d !== 8'h70) begin failures++; $display("FAIL inv_ctrl got=%h exp=70", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic got; logic [2:0] die;
    logic [2:0] exp_dies [3];
    exp_dies = '{3'd2, 3'd3, 3'd6};
    do_reset();
    loc_die = 3'd2; loc_req = 1'b1; tick(); loc_req = 1'b0;
    wait_start(got, die);
    checks++; if (got !== 1'b1 || die !== exp_dies[0]) begin failures++; $display("FAIL b2b_0 got=%b/%h exp=1/%h", got, die, exp_dies[0]); end
    tick();
    loc_die = 3'd3; loc_req = 1'b1; addr = ADDR_CTRL; wdata = 8'h62; wen = 1'b1; tick();
    wen = 1'b0; loc_die = 3'd4; tick(); loc_req = 1'b0;
    finish_roll(8'h45, 1);
    for (int i = 1; i < 3; i++) begin
      wait_start(got, die);
      checks++; if (got !== 1'b1 || die !== exp_dies[i]) begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, got, die, exp_dies[i]); end
      finish_roll(8'h46 + 8'(i), 1);
    end
    wait_start(got, die);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL b2b_dropped got=%b exp=0", got); end
    peek(ADDR_COUNT, d);
    checks++; if (d !== 8'h03) begin failures++; $display("FAIL b2b_count got=%h exp=03", d); end
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h48) begin failures++; $display("FAIL b2b_result got=%h exp=48", d); end
  endtask

  task automatic test_reset_mid_roll();
    logic [7:0] d; logic got; logic [2:0] die;
    do_reset();
    loc_die = 3'd5; loc_req = 1'b1; tick(); loc_req = 1'b0;
    wait_start(got, die); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    dp_result = 8'h77; dp_done = 1'b1; tick(); dp_done = 1'b0; tick();
    peek(ADDR_RESULT, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL mid_rst_result got=%h exp=01", d); end
    peek(ADDR_STATUS, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_rst_status got=%h exp=00", d); end
    wait_start(got, die);
    checks++; if (got !== 1'b0) begin failures++; $display("FAIL mid_rst_start got=%b exp=0", got); end
  endtask

  task automatic test_hist();
    logic [7:0] d, e; logic got; logic [2:0] die;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      loc_die = 3'd0; loc_req = 1'b1; tick(); loc_req = 1'b0;
      wait_start(got, die);
      m_src = 1'b0; finish_roll(8'(k), 1); model_complete(8'(k));
    end
    peek(ADDR_STATUS, d);
    checks++; if (d !== exp_status()) begin failures++; $display("FAIL hist_status got=%h exp=%h", d, exp_status()); end
    for (int k = 0; k < 5; k++) begin
      e = exp_hist();
      read_pop(ADDR_HIST, d);
      checks++; if (d !== e) begin failures++; $display("FAIL hist_read%0d got=%h exp=%h", k, d, e); end
      if (hist_q.size() > 0) void'(hist_q.pop_front());
    end
  endtask

  task automatic test_random();
    logic [2:0] ld, hd, die; logic hm, got; int kind;
    logic [7:0] res, d; logic [3:0] e;
    logic [3:0] rq[$];
    do_reset();
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 2);
      ld = 3'($urandom_range(0, 7)); hd = 3'($urandom_range(0, 7)); hm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin d = 8'($urandom); write_reg(ADDR_DISP, d); m_disp = d; end
      addr = ADDR_CTRL; rw = 1'b0;
      if (kind != 1) begin
        loc_req = 1'b1; loc_die = ld;
        if (ld == 3'd7) m_err = 1'b1; else rq.push_back({1'b0, ld});
      end
      if (kind != 0) begin
        wen = 1'b1; wdata = {1'b0, hd, 2'b00, 1'b1, hm}; m_hm = hm; m_cdie = hd;
        if (hd == 3'd7) m_err = 1'b1; else rq.push_back({1'b1, hd});
      end
      tick(); loc_req = 1'b0; wen = 1'b0;
      while (rq.size() > 0) begin
        e = rq.pop_front();
        wait_start(got, die);
        checks++; if (got !== 1'b1 || die !== e[2:0]) begin failures++; $display("FAIL rnd_start it=%0d got=%b/%h exp=1/%h", it, got, die, e[2:0]); end
        m_src = e[3];
        if ($urandom_range(0, 5) == 0) begin
          repeat (TO + 1) tick(); m_err = 1'b1;
        end else begin
          res = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          finish_roll(res, $urandom_range(1, 9)); model_complete(res);
        end
      end
      peek(ADDR_RESULT, d);
      checks++; if (d !== m_result) begin failures++; $display("FAIL rnd_result it=%0d got=%h exp=%h", it, d, m_result); end
      peek(ADDR_COUNT, d);
      checks++; if (d !== m_count) begin failures++; $display("FAIL rnd_count it=%0d got=%h exp=%h", it, d, m_count); end
      peek(ADDR_CTRL, d);
      checks++; if (d !== {1'b0, m_cdie, 3'b000, m_hm}) begin failures++; $display("FAIL rnd_ctrl it=%0d got=%h exp=%h", it, d, {1'b0, m_cdie, 3'b000, m_hm}); end
      checks++; if (disp_digits !== (m_hm ? m_disp : m_result) || disp_src !== m_hm) begin failures++; $display("FAIL rnd_disp it=%0d got=%h/%b exp=%h/%b", it, disp_digits, disp_src, (m_hm ? m_disp : m_result), m_hm); end
      read_pop(ADDR_STATUS, d);
      checks++; if (d !== exp_status()) begin failures++; $display("FAIL rnd_status it=%0d got=%h exp=%h", it, d, exp_status()); end
      m_done = 1'b0; m_err = 1'b0;
    end
  endtask

  initial begin
    idle_inputs(); rst = 1'b1;
    test_reset();
    test_local_roll();
    test_arbitration();
    test_timeout();
    test_display();
    test_invalid();
    test_back_to_back();
    test_reset_mid_roll();
    test_hist();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/dice_roll_ctrl.md
# dice_roll_ctrl

Roll sequencer and register controller between the I2C slave application interface, the local button decode and the dice datapath. It arbitrates roll requests from the local buttons and from the I2C host, and sequences one roll at a time through a start/done handshake with a watchdog. It latches results and decides whether the 7-segment path shows the roll result or host-written digits.

## Interface
Parameters:
- TIMEOUT_CYC, default 255: watchdog limit in cycles for `dp_done` after `dp_start`, range 1–255.
- RESET_MODE, default 0: reset value of CTRL.host_mode.

Ports:
- clk in 1: single clock; the whole block is on this clock.
- rst in 1: synchronous, active-high reset.
- rw in 1: I2C transaction direction from the slave; 1 = read.
- addr in 8: register address, stable whenever `wen` or `rdata_used` is high.
- wen in 1: one-cycle write strobe.
- wdata in 8: write data, qualified by `wen`.
- rdata_used in 1: one-cycle pulse when the slave consumes `rdata`.
- rdata out 8: read data for `addr`, registered.
- loc_req in 1: one-cycle local roll request pulse.
- loc_die in 3: die code for the local request.
- dp_start out 1: one-cycle start pulse to the datapath.
- dp_die out 3: die code, held from `dp_start` until the roll ends.
- dp_done in 1: one-cycle completion pulse from the datapath.
- dp_result in 8: BCD result {tens, ones}, valid with `dp_done`.
- disp_digits out 8: BCD digits to the segment mux.
- disp_src out 1: display source; 1 = host DISP register.

## Operation
- Die codes: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d100, 7=invalid.
- Register map:
  - 0x00 CTRL, R/W: [0] host_mode; [1] roll, write-1 pulse, reads 0; [6:4] host die code.
  - 0x01 STATUS, R: [0] busy; [1] done, sticky; [2] err, sticky; [3] last roll source, 1 = host. A read of STATUS (a `rdata_used` pulse with addr = 0x01) clears done and err.
  - 0x02 RESULT, R: last latched BCD result.
  - 0x03 DISP, R/W: host BCD digits.
  - 0x04 COUNT, R: completed rolls, 8-bit, wraps 255 → 0.
  - Unmapped addresses: read 0x00, writes are ignored.
- State machine:
  - IDLE → ISSUE when a request is pending.
  - ISSUE: `dp_start` = 1 for one cycle → WAIT.
  - WAIT → LATCH on `dp_done`.
  - WAIT → IDLE on watchdog expiry; sets err and does not update RESULT.
  - LATCH: RESULT ← `dp_result`, COUNT + 1, done ← 1 → IDLE.
- Request capture:
  - One pending slot per source.
  - A request arriving while busy is held in its slot.
  - A second request from the same source while its slot is full is dropped.
- Arbitration in IDLE: local slot wins over host slot when both are pending.
- Invalid die code (7) from either source: the request is rejected at capture, err is set, and no slot is filled.
- Display selection:
  - `disp_src` = host_mode.
  - `disp_digits` = DISP when host_mode = 1, else RESULT.
  - A local roll completion forces host_mode to 0 in the same cycle RESULT updates.
- Reset values: state IDLE, CTRL = {RESET_MODE}, STATUS = 0, RESULT = 0x01, DISP = 0x00, COUNT = 0, slots empty, `dp_start` = 0, `dp_die` = 0, `rdata` = 0.

## Timing
- Write to CTRL.roll in cycle N:
  - Host slot set at the N+1 edge.
  - `dp_start` high in cycle N+2 when IDLE and the local slot is empty.
- `loc_req` in cycle N with the block idle: `dp_start` high in cycle N+2.
- LATCH is one cycle after `dp_done`.
- busy = 1 from the cycle after capture through LATCH inclusive.
- `rdata` reflects `addr` with one-cycle latency. Register updates in cycle N are visible on `rdata` at N+1.
- Same-cycle write to DISP and LATCH: both take effect.
- Same-cycle STATUS read-clear and a set event: set wins.
- Watchdog counts cycles in WAIT and expires when the count reaches TIMEOUT_CYC.
- `rst` mid-roll: return to IDLE immediately. A later `dp_done` is ignored because the block is in IDLE.

## Configuration
- `DICE_ROLL_HIST_EN`:
  - Defined:
    - A 4-deep result history FIFO, written in LATCH.
    - When full, the oldest entry is overwritten.
    - Register 0x05 HIST: a read returns the oldest entry and pops it on `rdata_used`.
    - An empty FIFO reads 0x00.
    - STATUS[5:4] = entry count, saturating at 3 (4 entries also read as 3).
  - Undefined: 0x05 is unmapped and STATUS[5:4] read 0.

## Structure
- Package `dice_pkg`:
  - Die-code enum.
  - Register address localparams.
  - CTRL/STATUS bit indices.
  - FSM state enum (IDLE, ISSUE, WAIT, LATCH).
- One sub-module, `dice_hist_fifo` (4×8, overwrite-on-full), instantiated only under `DICE_ROLL_HIST_EN`.

## Test plan
- `loc_req` with die 1:
  - `dp_start` two cycles later with `dp_die` = 1.
  - `dp_done` with result 0x05 → RESULT = 0x05, COUNT = 1, STATUS = 0x02.
- Host write CTRL = 0x52 and `loc_req` (die 0) in the same cycle:
  - Local roll first, then host roll with die 5.
  - STATUS[3] = 1 after the second roll.
- No `dp_done` after `dp_start` with TIMEOUT_CYC = 10:
  - err set, RESULT unchanged, IDLE after 10 cycles in WAIT.
  - A STATUS read then returns err = 1, and the following STATUS read returns err = 0.
- Write DISP = 0x42 and CTRL = 0x01:
  - `disp_digits` = 0x42, `disp_src` = 1.
  - A following local roll completion → `disp_src` = 0, `disp_digits` = result.
- `loc_die` = 7: no `dp_start`, err set, COUNT unchanged.
- Under `DICE_ROLL_HIST_EN`:
  - Five rolls with results 0x01–0x05.
  - HIST reads return 0x02, 0x03, 0x04, 0x05, then 0x00.
